// File: rtl/mem_access_if.sv
// Pipeline/data-memory bus of the MEM-stage load/store unit.
// The slave modport is the unit itself; the master side is the pipeline plus memory.
interface mem_access_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 32,
    parameter int DM_ADDR_WIDTH = 30
);
    logic                     mem_read;
    logic                     mem_write;
    logic [1:0]               size;
    logic                     load_unsigned;
    logic [ADDR_WIDTH-1:0]    addr;
    logic [DATA_WIDTH-1:0]    store_data;
    logic [DATA_WIDTH-1:0]    load_data;
    logic                     stall;
    logic                     misalign;
    logic [7:0]               misalign_cnt;
    logic                     dm_wr_en;
    logic [DM_ADDR_WIDTH-1:0] dm_addr;
    logic [DATA_WIDTH-1:0]    dm_wr_data;
    logic [DATA_WIDTH-1:0]    dm_rd_data;

    modport master (
        output mem_read, mem_write, size, load_unsigned, addr, store_data, dm_rd_data,
        input  load_data, stall, misalign, misalign_cnt, dm_wr_en, dm_addr, dm_wr_data
    );

    modport slave (
        input  mem_read, mem_write, size, load_unsigned, addr, store_data, dm_rd_data,
        output load_data, stall, misalign, misalign_cnt, dm_wr_en, dm_addr, dm_wr_data
    );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: byte-addressed loads/stores onto a word memory,
// sub-word stores done as a two-cycle read-modify-write.
module mem_access_unit #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 32,
    parameter int DM_ADDR_WIDTH = 30
) (
    input  logic          clk,
    input  logic          rst,
    mem_access_if.slave   bus
);
    typedef enum logic {IDLE, MERGE} state_t;

    state_t                   state;
    logic [DATA_WIDTH-1:0]    rmw_word;
    logic [DM_ADDR_WIDTH-1:0] rmw_addr;
    logic [1:0]               rmw_lane;
    logic                     rmw_half;
    logic [15:0]              rmw_data;
    logic [7:0]               misalign_cnt_q;

    logic                     req, mis, ok, sub_store, word_store, do_load;
    logic [7:0]               ld_byte;
    logic [15:0]              ld_half;
    logic [DATA_WIDTH-1:0]    merged;

    assign req        = bus.mem_read | bus.mem_write;
    assign mis        = (bus.size == 2'b01 && bus.addr[0]) ||
                        (bus.size[1] && bus.addr[1:0] != 2'b00);
    // rst gates every request-derived output so nothing fires in the reset cycle
    assign ok         = !rst && state == IDLE && req && !mis;
    assign sub_store  = ok && bus.mem_write && !bus.size[1];
    assign word_store = ok && bus.mem_write && bus.size[1];
    assign do_load    = ok && !bus.mem_write;

    assign ld_byte = bus.dm_rd_data[{bus.addr[1:0], 3'b000} +: 8];
    assign ld_half = bus.addr[1] ? bus.dm_rd_data[31:16] : bus.dm_rd_data[15:0];

    always_comb begin
        bus.load_data = '0;
        if (do_load) begin
            case (bus.size)
                2'b00:   bus.load_data = {{(DATA_WIDTH-8){ld_byte[7] & ~bus.load_unsigned}}, ld_byte};
                2'b01:   bus.load_data = {{(DATA_WIDTH-16){ld_half[15] & ~bus.load_unsigned}}, ld_half};
                default: bus.load_data = bus.dm_rd_data;
            endcase
        end
    end

    always_comb begin
        merged = rmw_word;
        if (rmw_half) begin
            if (rmw_lane[1]) merged[31:16] = rmw_data;
            else             merged[15:0]  = rmw_data;
        end else begin
            case (rmw_lane)
                2'd0:    merged[7:0]   = rmw_data[7:0];
                2'd1:    merged[15:8]  = rmw_data[7:0];
                2'd2:    merged[23:16] = rmw_data[7:0];
                default: merged[31:24] = rmw_data[7:0];
            endcase
        end
    end

    assign bus.misalign     = !rst && state == IDLE && req && mis;
    assign bus.stall        = sub_store;
    assign bus.dm_wr_en     = word_store || (!rst && state == MERGE);
    assign bus.dm_addr      = (state == MERGE) ? rmw_addr : bus.addr[ADDR_WIDTH-1:2];
    assign bus.dm_wr_data   = (state == MERGE) ? merged : bus.store_data;
    assign bus.misalign_cnt = misalign_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            rmw_word       <= '0;
            rmw_addr       <= '0;
            rmw_lane       <= '0;
            rmw_half       <= 1'b0;
            rmw_data       <= '0;
            misalign_cnt_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sub_store) begin
                        rmw_word <= bus.dm_rd_data;
                        rmw_addr <= bus.addr[ADDR_WIDTH-1:2];
                        rmw_lane <= bus.addr[1:0];
                        rmw_half <= bus.size[0];
                        rmw_data <= bus.store_data[15:0];
                        state    <= MERGE;
                    end
                    if (bus.misalign && misalign_cnt_q != 8'hFF)
                        misalign_cnt_q <= misalign_cnt_q + 8'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store unit in the MEM stage, directly upstream of the word-addressed data memory.
- Converts byte addresses plus access size into word-indexed memory transactions.
- Sign- or zero-extends sub-word loads, and performs sub-word stores as a registered two-cycle read-modify-write.
- Flags misaligned accesses and stalls the pipeline during a read-modify-write.

Parameters:
- DATA_WIDTH, 32, data word width (fixed at 32 for the byte-lane logic).
- ADDR_WIDTH, 32, width of the incoming byte address.
- DM_ADDR_WIDTH, 30, width of the word index driven to the data memory (ADDR_WIDTH-2).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- mem_read  input  1  load request from EX/MEM.
- mem_write  input  1  store request from EX/MEM.
- size  input  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as word).
- load_unsigned  input  1  1 = zero-extend sub-word loads (lbu/lhu).
- addr  input  ADDR_WIDTH  byte address.
- store_data  input  DATA_WIDTH  store value; sub-word data is taken from its low bits.
- load_data  output  DATA_WIDTH  extended load result to MEM/WB.
- stall  output  1  freezes PC, IF/ID, ID/EX and EX/MEM.
- misalign  output  1  misaligned-access flag for the current request.
- misalign_cnt  output  8  saturating count of misaligned requests.
- dm_wr_en  output  1  data memory write enable.
- dm_addr  output  DM_ADDR_WIDTH  word index, addr[ADDR_WIDTH-1:2].
- dm_wr_data  output  DATA_WIDTH  word to write.
- dm_rd_data  input  DATA_WIDTH  combinational read data from data memory.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- Lane mapping is little-endian: addr[1:0]=0 selects bits 7:0 and addr[1:0]=3 selects bits 31:24. A halfword at addr[1]=0 is bits 15:0; at addr[1]=1 it is bits 31:16.
- Misalign conditions:
  - halfword with addr[0]=1;
  - word (or reserved size) with addr[1:0]!=0;
  - bytes never misalign.
- misalign is combinational, asserted only when in IDLE and (mem_read|mem_write) is set.
- A misaligned request:
  - performs no write;
  - drives load_data=0;
  - raises no stall;
  - increments misalign_cnt by 1 at the clock edge, saturating at 255.
- Loads: zero latency, fully combinational from dm_rd_data. The selected lane is sign-extended unless load_unsigned=1. When no valid load is present, load_data=0.
- If mem_read and mem_write are both 1, the request is treated as a store and load_data=0.
- FSM states: IDLE, MERGE.
- IDLE, aligned word store: dm_wr_en=1 and dm_wr_data=store_data in the same cycle. stall=0. Stay in IDLE.
- IDLE, aligned sub-word store:
  - stall=1, dm_wr_en=0;
  - at the clock edge, capture dm_rd_data into rmw_word, plus dm_addr, the lane and the low store bits;
  - go to MERGE.
- MERGE:
  - dm_addr = captured index;
  - dm_wr_data = rmw_word with the target lane replaced;
  - dm_wr_en=1, stall=0;
  - go to IDLE unconditionally.
  - New requests presented in MERGE are ignored (the pipeline still holds them stalled and re-presents them next cycle): misalign=0, load_data=0, counter unchanged.
- Consecutive sub-word stores alternate IDLE/MERGE, giving one stall cycle per store.
- Outside MERGE, dm_addr always equals addr[ADDR_WIDTH-1:2].
- Reset:
  - In the rst cycle: state->IDLE, rmw_word->0, misalign_cnt->0.
  - Outputs forced to stall=0, dm_wr_en=0, misalign=0, load_data=0.
  - Reset asserted during MERGE aborts the pending write: no partial write ever occurs.

Test Plan:
- Word mem[4]=0x11223344, lb addr=0x12 -> load_data=0x00000022; lh addr=0x12 -> 0x00001122; lbu addr=0x13 -> 0x00000011. All in the same cycle, stall=0.
- mem[2]=0x000080F0: lb addr=0x08 -> 0xFFFFFFF0; lh addr=0x08 -> 0xFFFF80F0; lhu addr=0x08 -> 0x000080F0.
- sw 0xDEADBEEF to addr=0x20 -> dm_wr_en=1 that cycle, dm_addr=8, stall=0. Then sb 0xAB to addr=0x21:
  - cycle 1: stall=1, dm_wr_en=0;
  - cycle 2: dm_wr_en=1, dm_wr_data=0xDEADABEF.
- sh 0x1234 to addr=0x22 over mem[8]=0xDEADABEF -> second cycle writes 0x1234ABEF. Back-to-back sb, sb -> stall pattern 1,0,1,0.
- Misaligned cases: lh addr=0x05, then sw addr=0x06 -> misalign=1 both cycles, no dm_wr_en, load_data=0, misalign_cnt=2. After 300 misaligned requests, misalign_cnt=255.
- sb in flight, rst asserted in MERGE -> dm_wr_en=0 that cycle, memory word unchanged, state IDLE, misalign_cnt=0.
